// File: rtl/bp_update_pkg.sv
// bp_update_pkg: shared definitions for the branch-predictor target table writer.
//   BP_AW      : table index / halfword address width
//   bp_addr_t  : one table address
//   bp_entry_t : one queued update, laid out as {pc, target}
//   addr_match : full-width address equality used by coalesce and lookup
package bp_update_pkg;

    localparam int BP_AW = 15;
    localparam int BP_EW = 2 * BP_AW;

    typedef logic [BP_AW-1:0] bp_addr_t;

    typedef struct packed {
        bp_addr_t pc;
        bp_addr_t target;
    } bp_entry_t;

    function automatic logic addr_match(input bp_addr_t a, input bp_addr_t b);
        return (a == b);
    endfunction

endpackage

// File: rtl/bp_update_queue.sv
// bp_upd_queue: circular update queue for the target-table writer.
// Holds entry storage, head/tail pointers and occupancy count, decides whether
// a new mispredict coalesces into a queued non-head entry or goes to the tail,
// and provides a youngest-wins lookup across all queued entries.
//   clk, reset  : clock, asynchronous active-high reset
//   wr_valid    : accepted mispredict to coalesce or enqueue
//   wr_entry    : {pc, target} of that mispredict
//   pop         : drain request; honoured only when an entry is present
//   full        : count == DEPTH
//   head_valid  : count != 0
//   head_entry  : oldest entry, zero when the queue is empty
//   lk_pc       : lookup address
//   lk_hit      : lk_pc matches a queued entry
//   lk_target   : youngest matching target, zero on miss
module bp_upd_queue
    import bp_update_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      wr_valid,
    input  bp_entry_t wr_entry,
    input  logic      pop,
    output logic      full,
    output logic      head_valid,
    output bp_entry_t head_entry,
    input  bp_addr_t  lk_pc,
    output logic      lk_hit,
    output bp_addr_t  lk_target
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam logic [PW-1:0]   PTR_ONE = PW'(1);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DEPTH);

    bp_entry_t       ent_q [DEPTH];
    bp_entry_t       ent_d [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CNTW-1:0] count_q, count_d;

    logic            co_hit_s;
    logic [PW-1:0]   co_idx_s;
    logic            do_push_s;
    logic            do_pop_s;

    // Occupancy status and the head presented to the table write port.
    always_comb begin
        head_valid = (count_q != {CNTW{1'b0}});
        full       = (count_q == CNT_MAX);
        if (head_valid) begin
            head_entry = ent_q[head_q];
        end else begin
            head_entry = '0;
        end
    end

    // Coalesce search over non-head entries; the head is being written this cycle,
    // so updating it would be lost. Later (younger) matches override earlier ones.
    always_comb begin
        co_hit_s = 1'b0;
        co_idx_s = head_q;
        for (int k = 1; k < DEPTH; k++) begin
            if ((CNTW'(k) < count_q) &&
                addr_match(ent_q[head_q + PW'(k)].pc, wr_entry.pc)) begin
                co_hit_s = 1'b1;
                co_idx_s = head_q + PW'(k);
            end else begin
                co_hit_s = co_hit_s;
            end
        end
    end

    // Fetch-side lookup including the head; scanning oldest to youngest lets the
    // youngest match win.
    always_comb begin
        lk_hit    = 1'b0;
        lk_target = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNTW'(k) < count_q) &&
                addr_match(ent_q[head_q + PW'(k)].pc, lk_pc)) begin
                lk_hit    = 1'b1;
                lk_target = ent_q[head_q + PW'(k)].target;
            end else begin
                lk_hit = lk_hit;
            end
        end
    end

    // Next-state for storage, pointers and count.
    always_comb begin
        ent_d     = ent_q;
        head_d    = head_q;
        tail_d    = tail_q;
        do_push_s = wr_valid && !co_hit_s;
        do_pop_s  = pop && head_valid;
        if (wr_valid && co_hit_s) begin
            ent_d[co_idx_s].target = wr_entry.target;
        end else begin
            ent_d[co_idx_s] = ent_q[co_idx_s];
        end
        if (do_push_s) begin
            ent_d[tail_q] = wr_entry;
            tail_d        = tail_q + PTR_ONE;
        end else begin
            tail_d = tail_q;
        end
        if (do_pop_s) begin
            head_d = head_q + PTR_ONE;
        end else begin
            head_d = head_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Queue state registers; reset empties the queue immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CNTW{1'b0}};
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bp_update.sv
// bp_update: writer side of the branch-predictor target table.
// Accepts resolved branches, drops correct predictions, queues mispredicted
// targets and drains one table write per cycle. Fetch can look up queued,
// not-yet-written targets. Keeps saturating branch / mispredict counters.
//   clk, reset                  : clock, asynchronous active-high reset
//   in_valid/in_ready           : resolved-branch handshake
//   in_pc/in_target/in_pred     : branch address, actual target, predicted target
//   wen/waddr/wdata             : table write port (head of queue)
//   lk_pc/lk_hit/lk_target      : fetch lookup bypass
//   br_cnt/mp_cnt               : accepted branches / accepted mispredicts
module bp_update
    import bp_update_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [14:0]   in_pc,
    input  logic [14:0]   in_target,
    input  logic [14:0]   in_pred,
    output logic          wen,
    output logic [14:0]   waddr,
    output logic [14:0]   wdata,
    input  logic [14:0]   lk_pc,
    output logic          lk_hit,
    output logic [14:0]   lk_target,
    output logic [CW-1:0] br_cnt,
    output logic [CW-1:0] mp_cnt
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          full_s;
    logic          head_valid_s;
    logic          accept_s;
    logic          mispredict_s;
    logic          deq_s;
    bp_entry_t     wr_entry_s;
    bp_entry_t     head_entry_s;
    logic [CW-1:0] br_cnt_q, br_cnt_d;
    logic [CW-1:0] mp_cnt_q, mp_cnt_d;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
        if (en && (v != CNT_MAX)) begin
            return v + CNT_ONE;
        end else begin
            return v;
        end
    endfunction

    // Every present head is written at the next edge, so it also pops then.
    assign deq_s = head_valid_s;

    bp_upd_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (mispredict_s),
        .wr_entry   (wr_entry_s),
        .pop        (deq_s),
        .full       (full_s),
        .head_valid (head_valid_s),
        .head_entry (head_entry_s),
        .lk_pc      (lk_pc),
        .lk_hit     (lk_hit),
        .lk_target  (lk_target)
    );

    // Handshake, prediction compare and write-port mapping.
    always_comb begin
        in_ready     = !full_s;
        accept_s     = in_valid && !full_s;
        mispredict_s = accept_s && (in_target != in_pred);
        wr_entry_s   = '{pc: in_pc, target: in_target};
        wen          = head_valid_s;
        waddr        = head_entry_s.pc;
        wdata        = head_entry_s.target;
        br_cnt       = br_cnt_q;
        mp_cnt       = mp_cnt_q;
    end

    // Saturating statistics next-state.
    always_comb begin
        br_cnt_d = sat_inc(br_cnt_q, accept_s);
        mp_cnt_d = sat_inc(mp_cnt_q, mispredict_s);
    end

    // Statistics counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_cnt_q <= {CW{1'b0}};
            mp_cnt_q <= {CW{1'b0}};
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

endmodule

// File: tb/tb_bp_update.sv
// tb_bp_update: self-checking bench for bp_update (DEPTH=4, CW=8 so saturation is reachable).
module tb_bp_update;

    localparam int TB_DEPTH = 4;
    localparam int TB_CW    = 8;
    localparam int SAT      = (1 << TB_CW) - 1;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [14:0]      in_pc;
    logic [14:0]      in_target;
    logic [14:0]      in_pred;
    logic             wen;
    logic [14:0]      waddr;
    logic [14:0]      wdata;
    logic [14:0]      lk_pc;
    logic             lk_hit;
    logic [14:0]      lk_target;
    logic [TB_CW-1:0] br_cnt;
    logic [TB_CW-1:0] mp_cnt;

    int total = 0;
    int bad   = 0;

    bp_update #(.DEPTH(TB_DEPTH), .CW(TB_CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_target (in_target),
        .in_pred   (in_pred),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .lk_pc     (lk_pc),
        .lk_hit    (lk_hit),
        .lk_target (lk_target),
        .br_cnt    (br_cnt),
        .mp_cnt    (mp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain FIFO of pending table updates plus two counters.
    typedef struct packed {
        logic [14:0] pc;
        logic [14:0] tgt;
    } ment_t;

    ment_t mq[$];
    int    m_br;
    int    m_mp;
    bit    stall;
    bit    stall_on;

    typedef struct {
        logic        v;
        logic [14:0] pc;
        logic [14:0] tgt;
        logic [14:0] pred;
        logic [14:0] lk;
        logic        e_rdy;
        logic        e_wen;
        logic [14:0] e_waddr;
        logic [14:0] e_wdata;
        logic        e_hit;
        logic [14:0] e_lkt;
        int          e_br;
        int          e_mp;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_br = 0;
        m_mp = 0;
    endtask

    // Holding the drain request low lets the bench fill the queue.
    task automatic apply_stall();
        if (stall && !stall_on) begin
            force dut.deq_s = 1'b0;
            stall_on = 1'b1;
        end else if (!stall && stall_on) begin
            release dut.deq_s;
            stall_on = 1'b0;
        end
    endtask

    task automatic check_model();
        int          n;
        logic        e_hit;
        logic [14:0] e_lkt;
        n     = mq.size();
        e_hit = 1'b0;
        e_lkt = 15'h0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!e_hit && mq[i].pc == lk_pc) begin
                e_hit = 1'b1;
                e_lkt = mq[i].tgt;
            end
        end
        check("in_ready", int'(in_ready), (n != TB_DEPTH) ? 1 : 0);
        check("wen", int'(wen), (n != 0) ? 1 : 0);
        check("waddr", int'(waddr), (n != 0) ? int'(mq[0].pc) : 0);
        check("wdata", int'(wdata), (n != 0) ? int'(mq[0].tgt) : 0);
        check("lk_hit", int'(lk_hit), int'(e_hit));
        check("lk_target", int'(lk_target), int'(e_lkt));
        check("br_cnt", int'(br_cnt), m_br);
        check("mp_cnt", int'(mp_cnt), m_mp);
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        bit acc;
        bit mis;
        bit pop;
        int ci;
        acc = in_valid && (mq.size() != TB_DEPTH);
        mis = acc && (in_target != in_pred);
        pop = (mq.size() != 0) && !stall;
        ci  = -1;
        if (mis) begin
            for (int i = 1; i < mq.size(); i++) begin
                if (mq[i].pc == in_pc) ci = i;
            end
        end
        if (acc && m_br < SAT) m_br++;
        if (mis && m_mp < SAT) m_mp++;
        if (mis && ci >= 0) mq[ci].tgt = in_target;
        if (pop) void'(mq.pop_front());
        if (mis && ci < 0) mq.push_back('{pc: in_pc, tgt: in_target});
    endtask

    task automatic drive(input logic v, input logic [14:0] pc, input logic [14:0] tgt,
                         input logic [14:0] pred, input logic [14:0] lk);
        @(negedge clk);
        apply_stall();
        in_valid  = v;
        in_pc     = pc;
        in_target = tgt;
        in_pred   = pred;
        lk_pc     = lk;
        #1;
    endtask

    task automatic commit();
        @(posedge clk);
        model_edge();
    endtask

    task automatic step_model(input logic v, input logic [14:0] pc, input logic [14:0] tgt,
                              input logic [14:0] pred, input logic [14:0] lk);
        drive(v, pc, tgt, pred, lk);
        check_model();
        commit();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [14:0] pool [6];
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_pc     = 15'h0;
        in_target = 15'h0;
        in_pred   = 15'h0;
        lk_pc     = 15'h0;
        stall     = 1'b0;
        stall_on  = 1'b0;
        model_clear();

        // Reset state
        #1;
        check("rst_wen", int'(wen), 0);
        check("rst_ready", int'(in_ready), 1);
        check("rst_lk_hit", int'(lk_hit), 0);
        check("rst_waddr", int'(waddr), 0);
        check("rst_br", int'(br_cnt), 0);
        check("rst_mp", int'(mp_cnt), 0);
        @(negedge clk);
        reset = 1'b0;

        // Correct prediction, then a single mispredict written for exactly one cycle
        vecs[0] = '{1'b1, 15'h0100, 15'h0200, 15'h0200, 15'h0100, 1'b1, 1'b0, 15'h0, 15'h0, 1'b0, 15'h0, 0, 0};
        vecs[1] = '{1'b0, 15'h0100, 15'h0000, 15'h0000, 15'h0100, 1'b1, 1'b0, 15'h0, 15'h0, 1'b0, 15'h0, 1, 0};
        vecs[2] = '{1'b1, 15'h0100, 15'h0300, 15'h0200, 15'h0100, 1'b1, 1'b0, 15'h0, 15'h0, 1'b0, 15'h0, 1, 0};
        vecs[3] = '{1'b0, 15'h0100, 15'h0000, 15'h0000, 15'h0100, 1'b1, 1'b1, 15'h0100, 15'h0300, 1'b1, 15'h0300, 2, 1};
        vecs[4] = '{1'b0, 15'h0100, 15'h0000, 15'h0000, 15'h0100, 1'b1, 1'b0, 15'h0, 15'h0, 1'b0, 15'h0, 2, 1};
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].v, vecs[i].pc, vecs[i].tgt, vecs[i].pred, vecs[i].lk);
            check("vec_ready", int'(in_ready), int'(vecs[i].e_rdy));
            check("vec_wen", int'(wen), int'(vecs[i].e_wen));
            check("vec_waddr", int'(waddr), int'(vecs[i].e_waddr));
            check("vec_wdata", int'(wdata), int'(vecs[i].e_wdata));
            check("vec_lk_hit", int'(lk_hit), int'(vecs[i].e_hit));
            check("vec_lk_target", int'(lk_target), int'(vecs[i].e_lkt));
            check("vec_br", int'(br_cnt), vecs[i].e_br);
            check("vec_mp", int'(mp_cnt), vecs[i].e_mp);
            commit();
        end

        // Full queue under a drain stall: 5th branch refused, counters frozen
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step_model(1'b1, 15'h0a00 + 15'(i), 15'h1000 + 15'(i), 15'h0, 15'h0a02);
        end
        for (int r = 0; r < 2; r++) begin
            drive(1'b1, 15'h0b00, 15'h1b00, 15'h0, 15'h0a02);
            check_model();
            check("full_ready", int'(in_ready), 0);
            check("full_br", int'(br_cnt), 4);
            check("full_mp", int'(mp_cnt), 4);
            check("full_lk_target", int'(lk_target), 'h1002);
            commit();
        end
        stall = 1'b0;
        drive(1'b1, 15'h0b00, 15'h1b00, 15'h0, 15'h0a02);
        check_model();
        check("drain_first_waddr", int'(waddr), 'h0a00);
        check("drain_first_wdata", int'(wdata), 'h1000);
        commit();
        step_model(1'b1, 15'h0b00, 15'h1b00, 15'h0, 15'h0b00);
        for (int i = 0; i < 6; i++) step_model(1'b0, 15'h0, 15'h0, 15'h0, 15'h0b00);
        check("after_drain_br", m_br, 5);
        check("after_drain_br_dut", int'(br_cnt), 5);

        // Coalesce into a non-head entry: two writes, second carries the new target
        do_reset();
        stall = 1'b1;
        step_model(1'b1, 15'h0010, 15'h0111, 15'h0, 15'h0020);
        step_model(1'b1, 15'h0020, 15'h0222, 15'h0, 15'h0020);
        step_model(1'b1, 15'h0020, 15'h0777, 15'h0, 15'h0020);
        stall = 1'b0;
        drive(1'b0, 15'h0, 15'h0, 15'h0, 15'h0020);
        check_model();
        check("co_w1_waddr", int'(waddr), 'h0010);
        check("co_w1_wdata", int'(wdata), 'h0111);
        check("co_lk_target", int'(lk_target), 'h0777);
        commit();
        drive(1'b0, 15'h0, 15'h0, 15'h0, 15'h0020);
        check_model();
        check("co_w2_wen", int'(wen), 1);
        check("co_w2_waddr", int'(waddr), 'h0020);
        check("co_w2_wdata", int'(wdata), 'h0777);
        commit();
        drive(1'b0, 15'h0, 15'h0, 15'h0, 15'h0020);
        check_model();
        check("co_no_w3", int'(wen), 0);
        check("co_mp", int'(mp_cnt), 3);
        commit();

        // Asynchronous reset mid-cycle with three entries queued
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_model(1'b1, 15'h0300 + 15'(i), 15'h0400 + 15'(i), 15'h0, 15'h0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        lk_pc    = 15'h0301;
        #2;
        check("arst_pre_wen", int'(wen), 1);
        reset = 1'b1;
        #1;
        check("arst_wen", int'(wen), 0);
        check("arst_waddr", int'(waddr), 0);
        check("arst_wdata", int'(wdata), 0);
        check("arst_ready", int'(in_ready), 1);
        check("arst_lk_hit", int'(lk_hit), 0);
        check("arst_lk_target", int'(lk_target), 0);
        check("arst_br", int'(br_cnt), 0);
        check("arst_mp", int'(mp_cnt), 0);
        model_clear();
        stall = 1'b0;
        apply_stall();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step_model(1'b0, 15'h0, 15'h0, 15'h0, 15'h0301);

        // Randomized traffic against the model, with occasional drain stalls
        do_reset();
        for (int i = 0; i < 6; i++) pool[i] = 15'h0040 + 15'(i * 3);
        for (int n = 0; n < 400; n++) begin
            logic [14:0] pred;
            logic [14:0] tgt;
            if ($urandom_range(0, 11) == 0) stall = !stall;
            pred = 15'($urandom);
            tgt  = ($urandom_range(0, 2) == 0) ? pred : 15'($urandom);
            step_model(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, pool[$urandom_range(0, 5)],
                       tgt, pred, pool[$urandom_range(0, 5)]);
        end
        stall = 1'b0;
        for (int i = 0; i < 6; i++) step_model(1'b0, 15'h0, 15'h0, 15'h0, 15'h0040);

        // Counter saturation
        do_reset();
        for (int i = 0; i < (1 << TB_CW) + 5; i++) begin
            step_model(1'b1, 15'h0040 + 15'(i % 8), 15'h0500 + 15'(i), 15'h0, 15'h0041);
        end
        drive(1'b0, 15'h0, 15'h0, 15'h0, 15'h0);
        check("sat_br", int'(br_cnt), SAT);
        check("sat_mp", int'(mp_cnt), SAT);
        commit();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
